// File: rtl/led_seq_pkg.sv
// Shared opcodes, modes and reset constants for the LED step sequencer.
package led_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_SET_PERIOD,
        OP_SET_PATTERN,
        OP_SET_MODE,
        OP_START,
        OP_STOP,
        OP_STEP,
        OP_RESET_SEQ
    } op_e;

    typedef enum logic [1:0] {
        MODE_ROT_L,
        MODE_ROT_R,
        MODE_BOUNCE,
        MODE_BLINK
    } mode_e;

    typedef enum logic {
        ST_RUN,
        ST_STOP
    } state_e;

    localparam int unsigned LED_SEQ_DEFAULT_PERIOD = 32'd5000000;
    localparam int unsigned LED_SEQ_RESET_PAT      = 32'd1;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step prescaler: counts clk cycles in RUN and ticks on the period boundary.
module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = LED_SEQ_DEFAULT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_restart,
    input  logic             i_set_period,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;

    // >= so that shrinking the period below the count wraps next cycle
    assign o_tick = i_run && (r_count >= r_period - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_period <= CNT_W'(DEFAULT_PERIOD);
        end else begin
            if (i_set_period)
                r_period <= (i_period == '0) ? CNT_W'(1) : i_period;
            if (i_restart || !i_run || o_tick)
                r_count <= '0;
            else
                r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Programmable LED sequencer with valid/ready command port.
// Optional step counter output enabled by LED_SEQ_STEPCNT_EN.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int          LED_W          = 16,
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = LED_SEQ_DEFAULT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_data,
    output logic [LED_W-1:0] led,
    output logic             running,
`ifdef LED_SEQ_STEPCNT_EN
    output logic             step_pulse,
    output logic [31:0]      step_count
`else
    output logic             step_pulse
`endif
);

    state_e           r_state, w_state_n;
    mode_e            r_mode, w_mode_n;
    op_e              r_pend_op, w_pend_op_n, w_app_op, w_op;
    logic [LED_W-1:0] r_pat, w_pat_n, r_led, w_led_n;
    logic [LED_W-1:0] r_pend_data, w_pend_data_n, w_app_data;
    logic             r_dir, w_dir_n, r_phase, w_phase_n;
    logic             r_pend, w_pend_n, r_pulse, w_pulse_n;
    logic             w_acc, w_tick, w_restart, w_step, w_app;
    logic             w_set_period, w_defer_op;

    function automatic logic [LED_W-1:0] rot_l(input logic [LED_W-1:0] p);
        return {p[LED_W-2:0], p[LED_W-1]};
    endfunction

    function automatic logic [LED_W-1:0] rot_r(input logic [LED_W-1:0] p);
        return {p[0], p[LED_W-1:1]};
    endfunction

    assign w_op         = op_e'(cmd_op);
    assign w_acc        = cmd_valid && cmd_ready;
    assign w_set_period = w_acc && (w_op == OP_SET_PERIOD);
    assign w_defer_op   = (w_op == OP_SET_PATTERN) || (w_op == OP_SET_MODE);

    led_seq_prescaler #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_presc (
        .clk          (clk),
        .rst          (rst),
        .i_run        (r_state == ST_RUN),
        .i_restart    (w_restart),
        .i_set_period (w_set_period),
        .i_period     (cmd_data[CNT_W-1:0]),
        .o_tick       (w_tick)
    );

    always_comb begin
        w_state_n     = r_state;
        w_pat_n       = r_pat;
        w_mode_n      = r_mode;
        w_dir_n       = r_dir;
        w_phase_n     = r_phase;
        w_pend_n      = r_pend;
        w_pend_op_n   = r_pend_op;
        w_pend_data_n = r_pend_data;
        w_pulse_n     = 1'b0;
        w_restart     = 1'b0;
        w_step        = 1'b0;
        w_app         = 1'b0;
        w_app_op      = r_pend_op;
        w_app_data    = r_pend_data;

        if (w_acc && w_op == OP_RESET_SEQ) begin
            w_state_n = ST_RUN;
            w_pat_n   = LED_W'(LED_SEQ_RESET_PAT);
            w_mode_n  = MODE_ROT_L;
            w_dir_n   = 1'b0;
            w_phase_n = 1'b0;
            w_pend_n  = 1'b0;
            w_restart = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (w_acc && w_op == OP_STOP) begin
                w_state_n = ST_STOP;
                w_restart = 1'b1;
                w_app     = r_pend;
                w_pend_n  = 1'b0;
            end else if (w_acc && w_op == OP_START) begin
                w_restart = 1'b1;
            end else begin
                // a pending op consumes the boundary instead of a step
                w_app  = w_tick && r_pend;
                w_step = w_tick && !r_pend;
                if (w_app)
                    w_pend_n = 1'b0;
                if (w_acc && w_defer_op) begin
                    w_pend_n      = 1'b1;
                    w_pend_op_n   = w_op;
                    w_pend_data_n = cmd_data[LED_W-1:0];
                end
            end
        end else begin
            w_step     = w_acc && (w_op == OP_STEP);
            w_app      = w_acc && w_defer_op;
            w_app_op   = w_op;
            w_app_data = cmd_data[LED_W-1:0];
            if (w_acc && w_op == OP_START) begin
                w_state_n = ST_RUN;
                w_restart = 1'b1;
            end
        end

        if (w_app) begin
            if (w_app_op == OP_SET_PATTERN) begin
                w_pat_n = w_app_data;
            end else begin
                w_mode_n  = mode_e'(w_app_data[1:0]);
                w_dir_n   = 1'b0;
                w_phase_n = 1'b0;
            end
        end

        if (w_step) begin
            w_pulse_n = 1'b1;
            unique case (r_mode)
                MODE_ROT_L: w_pat_n = rot_l(r_pat);
                MODE_ROT_R: w_pat_n = rot_r(r_pat);
                MODE_BOUNCE: begin
                    if (!r_dir && r_pat[LED_W-1]) begin
                        w_dir_n = 1'b1;
                        w_pat_n = rot_r(r_pat);
                    end else if (r_dir && r_pat[0]) begin
                        w_dir_n = 1'b0;
                        w_pat_n = rot_l(r_pat);
                    end else begin
                        w_pat_n = r_dir ? rot_r(r_pat) : rot_l(r_pat);
                    end
                end
                default: w_phase_n = !r_phase;
            endcase
        end

        w_led_n = (w_mode_n == MODE_BLINK && w_phase_n) ? '0 : w_pat_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pat       <= LED_W'(LED_SEQ_RESET_PAT);
            r_led       <= LED_W'(LED_SEQ_RESET_PAT);
            r_mode      <= MODE_ROT_L;
            r_dir       <= 1'b0;
            r_phase     <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_op   <= OP_NOP;
            r_pend_data <= '0;
            r_pulse     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_pat       <= w_pat_n;
            r_led       <= w_led_n;
            r_mode      <= w_mode_n;
            r_dir       <= w_dir_n;
            r_phase     <= w_phase_n;
            r_pend      <= w_pend_n;
            r_pend_op   <= w_pend_op_n;
            r_pend_data <= w_pend_data_n;
            r_pulse     <= w_pulse_n;
        end
    end

`ifdef LED_SEQ_STEPCNT_EN
    logic [31:0] r_step_count;

    always_ff @(posedge clk) begin
        if (rst || (w_acc && w_op == OP_RESET_SEQ))
            r_step_count <= '0;
        else if (w_pulse_n)
            r_step_count <= r_step_count + 32'd1;
    end

    assign step_count = r_step_count;
`endif

    assign cmd_ready  = !r_pend;
    assign led        = r_led;
    assign running    = (r_state == ST_RUN);
    assign step_pulse = r_pulse;

endmodule
